ula_muldiv_hilo: RTL and testbench
==================================

Name: ula_muldiv_hilo

Overview:
- Iterative multiply/divide unit in the execute stage, next to the ULA.
- Consumes the same A/B operand buses that feed the ULA.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, writes the 64-bit result into the HI/LO registers, and drives busy so the control unit can stall.
- HI/LO outputs feed the MFHI/MFLO result mux downstream of the ULA.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
OP  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
A  input  WIDTH  operand A (multiplicand / dividend), also MTHI/MTLO data
B  input  WIDTH  operand B (multiplier / divisor)
WHI  input  1  MTHI: write A into HI
WLO  input  1  MTLO: write A into LO
busy  output  1  operation in progress; start, WHI and WLO are ignored while high
done  output  1  one-cycle pulse in the cycle HI/LO first show a new mul/div result
div_zero  output  1  one-cycle pulse coincident with done when DIV/DIVU had B == 0
HI  output  WIDTH  product upper half / remainder
LO  output  WIDTH  product lower half / quotient

Behaviour:
- Reset: asynchronous, active-high.
  - HI = 0, LO = 0, busy = 0, done = 0, div_zero = 0, FSM = IDLE.
  - Asserting reset mid-operation aborts it. HI/LO take 0, not a partial result.
- FSM states: IDLE, CALC, FIN.
- IDLE, start = 1 at edge E0:
  - Latch OP.
  - Latch |A| and |B| (signed ops) or raw A/B (unsigned ops).
  - Latch the result-sign bits: sign_q = A[31]^B[31]; sign_r = A[31]. Both are 0 for unsigned ops.
  - Clear the iteration counter. Enter CALC, busy = 1.
  - Divide with B == 0: go straight to FIN instead of CALC.
- CALC: exactly WIDTH cycles (edges E1..E32), one bit per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle, remainder kept in a WIDTH+1-bit partial register.
  - After the WIDTH-th iteration enter FIN.
- FIN: one cycle (edge E33, or E1 for divide-by-zero). At that edge:
  - Sign-correct the result:
    - Product negated (2's complement, 64-bit) if sign_q.
    - Quotient negated if sign_q.
    - Remainder negated if sign_r.
  - Write HI/LO: MULT/MULTU → HI = upper, LO = lower. DIV/DIVU → HI = remainder, LO = quotient.
  - Divide by zero → HI = A as latched (original dividend), LO = all ones, div_zero = 1.
  - busy = 0, done = 1 for exactly one cycle. Return to IDLE.
- Latency: busy is high from after E0 until E33, i.e. 33 cycles. Divide-by-zero: busy high 1 cycle.
  - Back-to-back: start may be asserted in the same cycle done is high. It is accepted at that edge.
- Operands A/B are sampled only at E0. Later changes on A/B have no effect on the result.
- Boundary values:
  - -2^31 / -1 (DIV) → LO = 0x80000000, HI = 0. No trap, no flag.
  - Magnitude of -2^31 is handled as unsigned 0x80000000; no overflow.
- MTHI/MTLO:
  - In IDLE with start = 0: WHI loads HI <= A and WLO loads LO <= A at the next edge. Both may be set in the same cycle.
  - start and WHI/WLO together in IDLE: start wins, WHI/WLO are ignored.
  - While busy: WHI/WLO are ignored.
- HI/LO hold their value at all other times. They are not altered during CALC; intermediate values live in internal registers only.
- done and div_zero are registered outputs, never combinational from inputs.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7, start at E0 → busy 1 for 33 cycles; at E33 HI=0xFFFFFFFF, LO=0xFFFFFFEB, done=1 for one cycle, div_zero=0.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Back-to-back: DIV -7/2 with start high during the done cycle → LO=0xFFFFFFFD, HI=0xFFFFFFFF 33 cycles later.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0; DIVU A=100, B=7 → LO=14, HI=2.
- DIVU A=7, B=0 → at E1: done=1, div_zero=1, HI=7, LO=0xFFFFFFFF, busy low after E1.
- During a busy MULT: pulse start with different operands, then WHI with A=0x1234 → both ignored; the final result matches the original operands. In IDLE, WHI+WLO with A=0xCAFE → HI=LO=0xCAFE next edge.
- Start MULT 5*5, assert reset asynchronously at cycle 10 (between edges) → HI=LO=0, busy=0, done=0 immediately. After release, a new start completes normally (HI=0, LO=25).

Source files
------------

// File: rtl/ula_muldiv_hilo.sv
// ula_muldiv_hilo: iterative MULT/MULTU/DIV/DIVU unit that writes the HI/LO pair.
// One bit per cycle over WIDTH cycles, then one finishing cycle that sign-corrects
// the result and commits it to HI/LO. MTHI/MTLO write HI/LO directly while idle.
//
// Handshake: start is a request that is taken only at a rising edge where
// busy = 0, and start wins over WHI/WLO at that edge. busy stays high from
// the accepting edge until the edge that commits the result; done (and
// div_zero for a zero divisor) pulses for the single cycle in which HI/LO
// first show the new result. A new start may be raised in that done cycle.
module ula_muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WHI,
  input  logic             WLO,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operation context captured when a request is accepted
  logic               is_div_q;
  logic               dz_q;
  logic               sign_q;
  logic               sign_r;
  logic [WIDTH-1:0]   a_latched;
  logic [WIDTH-1:0]   b_mag;
  logic [CW-1:0]      cnt;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  // Divide: acc[WIDTH-1:0] holds dividend bits shifting out / quotient bits shifting in.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  // Operand decode on the live input buses
  logic               in_signed;
  logic               in_div_zero;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic               last_iter;

  // Sign-corrected results presented in FIN
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  // Operand magnitudes; -2^(WIDTH-1) maps to its unsigned magnitude with no overflow
  always_comb begin
    in_signed   = ~OP[0];
    in_div_zero = OP[1] && (B == '0);
    a_abs       = (in_signed && A[WIDTH-1]) ? -A : A;
    b_abs       = (in_signed && B[WIDTH-1]) ? -B : B;
  end

  // Single shift-add and single restoring-division step
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    // The partial's top bit is never set after a restoring step; it is
    // still honoured so the compare covers the full partial width.
    div_ge    = rem[WIDTH] | ~div_diff[WIDTH];
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // Final sign correction and HI/LO selection
  always_comb begin
    prod_fix = sign_q ? -acc : acc;
    quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fix[WIDTH-1:0];
    if (dz_q) begin
      fin_hi = a_latched;
      fin_lo = '1;
    end else if (is_div_q) begin
      fin_hi = rem_fix;
      fin_lo = quo_fix;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state; busy follows the registered state
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (start) state_next = in_div_zero ? FIN : CALC;
      CALC: if (last_iter) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, HI/LO and status pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      a_latched <= '0;
      b_mag     <= '0;
      cnt       <= '0;
      acc       <= '0;
      rem       <= '0;
      HI        <= '0;
      LO        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div_q  <= OP[1];
            dz_q      <= in_div_zero;
            sign_q    <= in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r    <= in_signed & A[WIDTH-1];
            a_latched <= A;
            b_mag     <= b_abs;
            acc       <= {{WIDTH{1'b0}}, a_abs};
            rem       <= '0;
            cnt       <= '0;
          end else begin
            if (WHI) HI <= A;
            if (WLO) LO <= A;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div_q) begin
            rem            <= div_ge ? div_diff : div_shift;
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_next;
          end
        end
        FIN: begin
          HI       <= fin_hi;
          LO       <= fin_lo;
          done     <= 1'b1;
          div_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv_hilo.sv
// tb_ula_muldiv_hilo: directed and randomized checks of the mul/div HI/LO unit
// against an arithmetic reference model using 64-bit integer math.
module tb_ula_muldiv_hilo;

  localparam int WIDTH = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic        WHI;
  logic        WLO;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {div_zero, HI, LO} per accepted operation, in issue order
  logic [64:0] exp_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  ula_muldiv_hilo #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .OP       (OP),
    .A        (A),
    .B        (B),
    .WHI      (WHI),
    .WLO      (WLO),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .HI       (HI),
    .LO       (LO)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic. SV division truncates
  // toward zero and the remainder takes the dividend's sign.
  function automatic logic [64:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: begin p = sa * sb; return {1'b0, p}; end
      2'd1: begin p = ua * ub; return {1'b0, p}; end
      2'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = ua / ub;
        r = ua % ub;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit mt_too);
    OP    = op;
    A     = a;
    B     = b;
    start = 1'b1;
    WHI   = mt_too;
    WLO   = mt_too;
    exp_q.push_back(ref_result(op, a, b));
    @(negedge clock);
    start = 1'b0;
    WHI   = 1'b0;
    WLO   = 1'b0;
    A     = $urandom;
    B     = $urandom;
    check("busy_after_start", 65'(busy), 65'(1));
    check("done_low_after_start", 65'(done), 65'(0));
  endtask

  task automatic wait_done(input logic [1:0] op, input logic [31:0] b, input bit disturb);
    int cyc = 0;
    int busy_cnt = 0;
    int exp_busy;
    logic [64:0] exp;
    exp_busy = (op[1] && b == 32'd0) ? 1 : WIDTH + 1;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      if (cyc == 0) check("hilo_hold_busy", {1'b0, HI, LO}, {1'b0, model_hi, model_lo});
      if (disturb) begin
        if (cyc == 4) begin start = 1'b1; OP = 2'($urandom); A = $urandom; B = $urandom; end
        if (cyc == 5) begin start = 1'b0; WHI = 1'b1; WLO = 1'b1; A = 32'h1234; end
        if (cyc == 6) begin WHI = 1'b0; WLO = 1'b0; end
      end
      @(negedge clock);
      cyc++;
    end
    check("done_seen", 65'(done), 65'(1));
    if (!done) return;
    exp = exp_q.pop_front();
    check("result", {div_zero, HI, LO}, exp);
    check("busy_cycles", 65'(busy_cnt), 65'(exp_busy));
    check("busy_low_at_done", 65'(busy), 65'(0));
    model_hi = exp[63:32];
    model_lo = exp[31:0];
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit disturb, input bit mt_too);
    issue(op, a, b, mt_too);
    wait_done(op, b, disturb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("done_pulse_width", 65'(done), 65'(0));
      check("hilo_hold_idle", {1'b0, HI, LO}, {1'b0, model_hi, model_lo});
    end
  endtask

  task automatic mt(input logic whi, input logic wlo, input logic [31:0] a);
    WHI = whi;
    WLO = wlo;
    A   = a;
    @(negedge clock);
    WHI = 1'b0;
    WLO = 1'b0;
    if (whi) model_hi = a;
    if (wlo) model_lo = a;
    check("mt_hilo", {1'b0, HI, LO}, {1'b0, model_hi, model_lo});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    WHI   = 1'b0;
    WLO   = 1'b0;
    OP    = 2'd0;
    A     = '0;
    B     = '0;
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clock);
    check("reset_state", {busy, done, div_zero, HI, LO}, 99'(0));
    reset = 1'b0;
    @(negedge clock);

    // MULT -3 * 7
    run(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("mult_neg_lo", 65'(LO), 65'(32'hFFFF_FFEB));
    idle(1);

    // MULTU max*max, then DIV -7/2 started in the done cycle
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max_hi", 65'(HI), 65'(32'hFFFF_FFFE));
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_b2b", {1'b0, HI, LO}, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    idle(1);

    // -2^31 / -1 and DIVU 100/7
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_min_neg1", {div_zero, HI, LO}, {1'b0, 32'h0, 32'h8000_0000});
    idle(1);
    run(2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_100_7", {1'b0, HI, LO}, {1'b0, 32'd2, 32'd14});
    idle(1);

    // Divide by zero
    run(2'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divu_zero", {div_zero, HI, LO}, {1'b1, 32'd7, 32'hFFFF_FFFF});
    idle(2);

    // start / WHI / WLO ignored while busy
    run(2'd0, 32'd3, 32'hFFFF_FFFB, 1'b1, 1'b0);
    idle(1);

    // MTHI/MTLO in idle, single and both; start beats WHI/WLO
    mt(1'b1, 1'b1, 32'h0000_CAFE);
    mt(1'b1, 1'b0, 32'h1111_2222);
    mt(1'b0, 1'b1, 32'h3333_4444);
    run(2'd1, 32'h10, 32'h20, 1'b0, 1'b1);
    idle(1);

    // Randomized operations with idle gaps, back-to-back starts and MT writes
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      run(op, a, b, 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Asynchronous reset mid-operation
    mt(1'b1, 1'b1, 32'hBEEF_0001);
    issue(2'd0, 32'd5, 32'd5, 1'b0);
    repeat (9) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_abort", {busy, done, div_zero, HI, LO}, 99'(0));
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run(2'd0, 32'd5, 32'd5, 1'b0, 1'b0);
    check("mult_after_reset", {1'b0, HI, LO}, {1'b0, 32'd0, 32'd25});
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
